// File: rtl/decode_queue.sv
// decode_queue: fetch-to-decode instruction FIFO with enqueue-time predecode and flush.
// Optional zero-latency empty-queue bypass is enabled by defining DECODE_QUEUE_BYPASS_EN.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [31:0]      out_instr,
    output logic             out_pre_branch,
    output logic             out_pre_jump,
    output logic             out_pre_cop0,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] C_FULL = (PTR_W + 1)'(DEPTH);

    // Class bits packed as {branch, jump, cop0}; encodings are mutually exclusive by opcode.
    function automatic logic [2:0] predecode(input logic [31:0] instr);
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] fn;
        logic       br;
        logic       jp;
        logic       c0;
        op = instr[31:26];
        rs = instr[25:21];
        rt = instr[20:16];
        fn = instr[5:0];
        br = (op == 6'd4) || (op == 6'd5) || (op == 6'd6) || (op == 6'd7) ||
             ((op == 6'd1) && ((rt == 5'd0) || (rt == 5'd1) || (rt == 5'd16) || (rt == 5'd17)));
        jp = (op == 6'd2) || (op == 6'd3) ||
             ((op == 6'd0) && ((fn == 6'd8) || (fn == 6'd9)));
        c0 = ((op == 6'd0) && (fn == 6'd12)) ||
             ((op == 6'd16) && ((rs == 5'd0) || (rs == 5'd4) || (fn == 6'd24)));
        return {br, jp, c0};
    endfunction

    logic [PC_W-1:0] r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [2:0]      r_pre_mem   [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic       w_not_empty;
    logic       w_bypass;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_in_pre;
    logic [2:0] w_head_pre;

    assign w_in_pre    = predecode(in_instr);
    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count != C_FULL);
    assign count       = r_count;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign w_bypass = ~w_not_empty & in_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign out_valid = w_not_empty | w_bypass;

    // A bypassed instruction that the decoder takes immediately is never written.
    assign w_push = in_valid & in_ready & ~flush & ~(w_bypass & out_ready);
    assign w_pop  = w_not_empty & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: out_valid gates everything read from it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pre_mem[r_wr_ptr]   <= w_in_pre;
        end
    end

    always_comb begin
        out_pc     = '0;
        out_instr  = '0;
        w_head_pre = '0;
        if (w_bypass) begin
            out_pc     = in_pc;
            out_instr  = in_instr;
            w_head_pre = w_in_pre;
        end else if (w_not_empty) begin
            out_pc     = r_pc_mem[r_rd_ptr];
            out_instr  = r_instr_mem[r_rd_ptr];
            w_head_pre = r_pre_mem[r_rd_ptr];
        end
    end

    assign out_pre_branch = w_head_pre[2];
    assign out_pre_jump   = w_head_pre[1];
    assign out_pre_cop0   = w_head_pre[0];

endmodule
